// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Quotient/remainder/div_by_zero hold until the next completion.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] q_work, q_next;
  // The partial remainder is always below the divisor, so its top bit is
  // always zero and only WIDTH bits are stored.
  logic [WIDTH-1:0] r_work, r_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] quot_next, rem_next;
  logic             dbz_next;
  logic [WIDTH:0]   rs, diff;
  logic [WIDTH-1:0] q_step, r_step;

  // Next-state, iteration datapath and result capture
  always_comb begin
    state_next = state;
    count_next = count;
    q_next     = q_work;
    r_next     = r_work;
    div_next   = div_reg;
    quot_next  = quotient;
    rem_next   = remainder;
    dbz_next   = div_by_zero;

    rs     = {r_work, q_work[WIDTH-1]};
    diff   = rs - {1'b0, div_reg};
    q_step = {q_work[WIDTH-2:0], ~diff[WIDTH]};
    r_step = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];

    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          if (divisor != '0) begin
            div_next   = divisor;
            q_next     = dividend;
            r_next     = '0;
            count_next = '0;
            state_next = RUN;
          end else begin
            quot_next  = '1;
            rem_next   = dividend;
            dbz_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        q_next     = q_step;
        r_next     = r_step;
        count_next = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          quot_next  = q_step;
          rem_next   = r_step;
          dbz_next   = 1'b0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      q_work      <= '0;
      r_work      <= '0;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      q_work      <= q_next;
      r_work      <= r_next;
      div_reg     <= div_next;
      quotient    <= quot_next;
      remainder   <= rem_next;
      div_by_zero <= dbz_next;
      busy        <= (state_next == RUN);
      done        <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): vector table, handshake
// corner sequences and a randomized sweep against an arithmetic reference.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one accepted start and wait (bounded) until done is seen
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt);
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention
  task automatic ref_div(input int a, input int b, output int q, output int r, output int dbz);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dbz = 1;
    end else begin
      q = a / b; r = a % b; dbz = 0;
    end
  endtask

  initial begin
    int lat, bc, nd, rq, rr, rd, a, b, got_q, got_r;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dbz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dbz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dbz: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dbz: 1'b0};
    vecs[5] = '{a: 8'd42,  b: 8'd0,   q: 8'hFF,  r: 8'd42, dbz: 1'b1};
    vecs[6] = '{a: 8'd9,   b: 8'd4,   q: 8'd2,   r: 8'd1,  dbz: 1'b0};

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    reset = 1'b0;
    step();

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].b != 0) ? W : 0);
      check($sformatf("vec%0d_busy_cycles", i), bc, (vecs[i].b != 0) ? W : 0);
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
      step();
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
      check($sformatf("vec%0d_hold_quotient", i), quotient, vecs[i].q);
    end

    // Start pulsed during RUN must be ignored
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    step();
    nd = 0; got_q = 0; got_r = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) begin
        start = 1'b1; dividend = 8'd10; divisor = 8'd2;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        nd++; got_q = quotient; got_r = remainder;
      end
    end
    check("ignore_done_pulses", nd, 1);
    check("ignore_quotient", got_q, 66);
    check("ignore_remainder", got_r, 2);

    // Back-to-back: new start held in the DONE cycle
    run_op(8'd100, 8'd7, lat, bc);
    check("b2b_first_done", done, 1);
    check("b2b_first_quotient", quotient, 14);
    check("b2b_first_remainder", remainder, 2);
    run_op(8'd50, 8'd6, lat, bc);
    check("b2b_second_latency", lat, W);
    check("b2b_second_quotient", quotient, 8);
    check("b2b_second_remainder", remainder, 2);
    step();

    // Reset during RUN iteration 4 aborts the operation
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    check("midrun_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrun_busy", busy, 0);
    check("midrun_done", done, 0);
    check("midrun_quotient", quotient, 0);
    check("midrun_remainder", remainder, 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) nd++;
    end
    check("midrun_no_done", nd, 0);

    // Reset and start together: reset wins
    reset = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    reset = 1'b0; start = 1'b0;
    check("reset_start_busy", busy, 0);
    step();
    check("reset_start_stays_idle", busy, 0);

    // Randomized sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255);
      run_op(W'(a), W'(b), lat, bc);
      ref_div(a, b, rq, rr, rd);
      check($sformatf("rand%0d_%0d_div_%0d_quotient", i, a, b), quotient, rq);
      check($sformatf("rand%0d_%0d_div_%0d_remainder", i, a, b), remainder, rr);
      check($sformatf("rand%0d_%0d_div_%0d_dbz", i, a, b), div_by_zero, rd);
      if (b != 0)
        check($sformatf("rand%0d_invariant", i),
              int'(quotient) * b + int'(remainder) == a && int'(remainder) < b, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
